// File: rtl/mtl_timing_gen_avalon.sv
// mtl_timing_gen_avalon: LCD timing generator with Avalon-MM control, windowed pixel stream, optional test pattern (MTL_TEST_PATTERN_EN)
module mtl_timing_gen_avalon #(
    parameter int H_LINE  = 1056,
    parameter int V_LINE  = 525,
    parameter int H_BLANK = 46,
    parameter int H_FP    = 210,
    parameter int V_BLANK = 23,
    parameter int V_FP    = 22,
    parameter int CW      = 8
) (
    input  logic              Avalon_CLK_50,
    input  logic              Avalon_reset,
    input  logic [3:0]        Avalon_address,
    input  logic              Avalon_read,
    output logic [31:0]       Avalon_readdata,
    input  logic              Avalon_write,
    input  logic [31:0]       Avalon_writedata,
    output logic              irq,
    input  logic [3*CW-1:0]   iPIX_DATA,
    input  logic              iPIX_VALID,
    output logic              oPIX_REQ,
    output logic              oHD,
    output logic              oVD,
    output logic              oDE,
    output logic [CW-1:0]     oLCD_R,
    output logic [CW-1:0]     oLCD_G,
    output logic [CW-1:0]     oLCD_B,
    output logic              oNewFrame,
    output logic              oEndFrame
);
    localparam int PW = 3 * CW;
    localparam int BW = (H_LINE - H_BLANK - H_FP) / 8;
`ifdef MTL_TEST_PATTERN_EN
    localparam logic TP_EN = 1'b1;
`else
    localparam logic TP_EN = 1'b0;
`endif

    logic [10:0]   x_q, x_d, ax;
    logic [9:0]    y_q, y_d, ay;
    logic          hd_q, hd_d, vd_q, vd_d, de_q, de_d;
    logic [PW-1:0] rgb_q, rgb_d, bg_q, bg_d, bar_rgb;
    logic [31:0]   rdata_q, rdata_d;
    logic          en_q, en_d, ie_q, ie_d, tp_q, tp_d;
    logic          eof_q, eof_d, uf_q, uf_d;
    logic [10:0]   wx0_q, wx0_d, wx1_q, wx1_d, sx0_q, sx0_d, sx1_q, sx1_d;
    logic [9:0]    wy0_q, wy0_d, wy1_q, wy1_d, sy0_q, sy0_d, sy1_q, sy1_d;
    logic [15:0]   fc_q, fc_d;
    logic          en_s_q, en_s_d, tp_s_q, tp_s_d;
    logic          act, in_win;
    logic [2:0]    bi;
    logic          wr_ctrl, wr_stat, wr_bg, wr_wx, wr_wy;
    logic          unused_wdata;

    assign wr_ctrl = Avalon_write && Avalon_address == 4'd0;
    assign wr_stat = Avalon_write && Avalon_address == 4'd1;
    assign wr_bg   = Avalon_write && Avalon_address == 4'd2;
    assign wr_wx   = Avalon_write && Avalon_address == 4'd3;
    assign wr_wy   = Avalon_write && Avalon_address == 4'd4;
    assign unused_wdata = ^Avalon_writedata;

    assign irq = ie_q & eof_q;
    assign oHD = hd_q;
    assign oVD = vd_q;
    assign oDE = de_q;
    assign {oLCD_R, oLCD_G, oLCD_B} = rgb_q;
    assign Avalon_readdata = rdata_q;

    // Decode the current counter position: active area, window membership, frame markers, bar colour
    always_comb begin
        ax = x_q - 11'(H_BLANK);
        ay = y_q - 10'(V_BLANK);
        act = x_q >= 11'(H_BLANK) && x_q < 11'(H_LINE - H_FP) &&
              y_q >= 10'(V_BLANK) && y_q < 10'(V_LINE - V_FP);
        in_win = ax >= sx0_q && ax <= sx1_q && ay >= sy0_q && ay <= sy1_q;
        bi = 3'(ax / 11'(BW));
        bar_rgb = {{CW{~bi[1]}}, {CW{~bi[2]}}, {CW{~bi[0]}}};
        oNewFrame = !Avalon_reset && x_q == '0 && y_q == '0;
        oEndFrame = x_q == 11'(H_LINE - H_FP - 1) && y_q == 10'(V_LINE - V_FP - 1);
        oPIX_REQ = en_s_q & act & in_win & ~tp_s_q;
    end

    // Next state: counters, registered video outputs, register file, shadows, status events
    always_comb begin
        x_d = (x_q == 11'(H_LINE - 1)) ? '0 : x_q + 11'd1;
        y_d = (x_q != 11'(H_LINE - 1)) ? y_q : (y_q == 10'(V_LINE - 1)) ? '0 : y_q + 10'd1;
        hd_d = x_q != '0;
        vd_d = y_q != '0;
        de_d = act;
        rgb_d = (!en_s_q || !act) ? '0 : !in_win ? bg_q : tp_s_q ? bar_rgb :
                iPIX_VALID ? iPIX_DATA : bg_q;
        en_d = wr_ctrl ? Avalon_writedata[0] : en_q;
        ie_d = wr_ctrl ? Avalon_writedata[1] : ie_q;
        tp_d = TP_EN & (wr_ctrl ? Avalon_writedata[2] : tp_q);
        eof_d = oEndFrame | (eof_q & ~(wr_stat & Avalon_writedata[0]));
        uf_d = (oPIX_REQ & ~iPIX_VALID) | (uf_q & ~(wr_stat & Avalon_writedata[1]));
        bg_d = wr_bg ? Avalon_writedata[PW-1:0] : bg_q;
        wx0_d = wr_wx ? Avalon_writedata[10:0] : wx0_q;
        wx1_d = wr_wx ? Avalon_writedata[26:16] : wx1_q;
        wy0_d = wr_wy ? Avalon_writedata[9:0] : wy0_q;
        wy1_d = wr_wy ? Avalon_writedata[25:16] : wy1_q;
        fc_d = oEndFrame ? fc_q + 16'd1 : fc_q;
        en_s_d = oNewFrame ? en_q : en_s_q;
        tp_s_d = oNewFrame ? tp_q : tp_s_q;
        sx0_d = oNewFrame ? wx0_q : sx0_q;
        sx1_d = oNewFrame ? wx1_q : sx1_q;
        sy0_d = oNewFrame ? wy0_q : sy0_q;
        sy1_d = oNewFrame ? wy1_q : sy1_q;
    end

    // Read mux; readback shows programmed values, not the frame-latched shadows
    always_comb begin
        rdata_d = '0;
        if (Avalon_read) begin
            case (Avalon_address)
                4'd0:    rdata_d = {29'd0, tp_q, ie_q, en_q};
                4'd1:    rdata_d = {30'd0, uf_q, eof_q};
                4'd2:    rdata_d = 32'(bg_q);
                4'd3:    rdata_d = {5'd0, wx1_q, 5'd0, wx0_q};
                4'd4:    rdata_d = {6'd0, wy1_q, 6'd0, wy0_q};
                4'd5:    rdata_d = {16'd0, fc_q};
                default: rdata_d = '0;
            endcase
        end
    end

    // State register
    always_ff @(posedge Avalon_CLK_50) begin
        if (Avalon_reset) begin
            x_q <= '0;
            y_q <= '0;
            hd_q <= 1'b0;
            vd_q <= 1'b1;
            de_q <= 1'b0;
            rgb_q <= '0;
            rdata_q <= '0;
            en_q <= 1'b0;
            ie_q <= 1'b0;
            tp_q <= 1'b0;
            eof_q <= 1'b0;
            uf_q <= 1'b0;
            bg_q <= '0;
            wx0_q <= '0;
            wx1_q <= '0;
            wy0_q <= '0;
            wy1_q <= '0;
            fc_q <= '0;
            en_s_q <= 1'b0;
            tp_s_q <= 1'b0;
            sx0_q <= '0;
            sx1_q <= '0;
            sy0_q <= '0;
            sy1_q <= '0;
        end else begin
            x_q <= x_d;
            y_q <= y_d;
            hd_q <= hd_d;
            vd_q <= vd_d;
            de_q <= de_d;
            rgb_q <= rgb_d;
            rdata_q <= rdata_d;
            en_q <= en_d;
            ie_q <= ie_d;
            tp_q <= tp_d;
            eof_q <= eof_d;
            uf_q <= uf_d;
            bg_q <= bg_d;
            wx0_q <= wx0_d;
            wx1_q <= wx1_d;
            wy0_q <= wy0_d;
            wy1_q <= wy1_d;
            fc_q <= fc_d;
            en_s_q <= en_s_d;
            tp_s_q <= tp_s_d;
            sx0_q <= sx0_d;
            sx1_q <= sx1_d;
            sy0_q <= sy0_d;
            sy1_q <= sy1_d;
        end
    end
endmodule

// File: tb/tb_mtl_timing_gen_avalon.sv
// tb_mtl_timing_gen_avalon: scoreboard bench on a reduced 24x8 raster (active 16x5)
module tb_mtl_timing_gen_avalon;
    localparam int HL = 24, HB = 2, HF = 6, VL = 8, VB = 2, VF = 1, CW = 8;
    localparam int FRAME = HL * VL;
`ifdef MTL_TEST_PATTERN_EN
    localparam bit TP = 1'b1;
`else
    localparam bit TP = 1'b0;
`endif

    logic clk = 1'b0;
    logic Avalon_reset = 1'b1;
    logic [3:0] Avalon_address = '0;
    logic Avalon_read = 1'b0, Avalon_write = 1'b0;
    logic [31:0] Avalon_readdata, Avalon_writedata = '0;
    logic irq, iPIX_VALID = 1'b0, oPIX_REQ, oHD, oVD, oDE, oNewFrame, oEndFrame;
    logic [3*CW-1:0] iPIX_DATA = '0;
    logic [CW-1:0] oLCD_R, oLCD_G, oLCD_B;

    mtl_timing_gen_avalon #(.H_LINE(HL), .V_LINE(VL), .H_BLANK(HB), .H_FP(HF),
                            .V_BLANK(VB), .V_FP(VF), .CW(CW)) dut (
        .Avalon_CLK_50(clk), .Avalon_reset(Avalon_reset), .Avalon_address(Avalon_address),
        .Avalon_read(Avalon_read), .Avalon_readdata(Avalon_readdata), .Avalon_write(Avalon_write),
        .Avalon_writedata(Avalon_writedata), .irq(irq), .iPIX_DATA(iPIX_DATA),
        .iPIX_VALID(iPIX_VALID), .oPIX_REQ(oPIX_REQ), .oHD(oHD), .oVD(oVD), .oDE(oDE),
        .oLCD_R(oLCD_R), .oLCD_G(oLCD_G), .oLCD_B(oLCD_B), .oNewFrame(oNewFrame),
        .oEndFrame(oEndFrame));

    always #5 clk = ~clk;

    int checks = 0, failures = 0;
    logic [23:0] pix_exp[$];
    logic [31:0] rd_exp[$];
    logic [23:0] bars[8] = '{24'hFFFFFF, 24'hFFFF00, 24'h00FFFF, 24'h00FF00,
                             24'hFF00FF, 24'hFF0000, 24'h0000FF, 24'h000000};

    // reference model state
    int mx, my, drop, nf_cnt, hd_low, req_cnt;
    logic r_en, r_ie, r_tp, s_en, s_tp, eof, uf, prev_hd, prev_vd;
    logic [10:0] r_x0, r_x1, s_x0, s_x1;
    logic [9:0] r_y0, r_y1, s_y0, s_y1;
    logic [23:0] r_bg, pdat;
    logic [15:0] fc;

    task automatic check(input string n, input logic [31:0] a, input logic [31:0] e);
        checks++;
        if (a !== e) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", n, a, e);
        end
    endtask

    // monitor: pops expectations whenever the DUT presents a pixel or read data
    int de_cnt = 0, bg_seen = 0;
    logic rv = 1'b0;
    always @(posedge clk) rv <= Avalon_read;
    always @(negedge clk) begin
        if (oDE === 1'b1) begin
            de_cnt++;
            if ({oLCD_R, oLCD_G, oLCD_B} == 24'h123456) bg_seen++;
            if (pix_exp.size() == 0) check("pix_unexpected", {oLCD_R, oLCD_G, oLCD_B}, 32'hDEAD);
            else check("pixel", {oLCD_R, oLCD_G, oLCD_B}, pix_exp.pop_front());
        end
        if (rv) begin
            if (rd_exp.size() == 0) check("rd_unexpected", Avalon_readdata, 32'hDEAD);
            else check("readdata", Avalon_readdata, rd_exp.pop_front());
        end
    end

    function automatic logic [31:0] rd_model(input logic [3:0] a);
        case (a)
            4'd0: return {29'd0, r_tp, r_ie, r_en};
            4'd1: return {30'd0, uf, eof};
            4'd2: return {8'd0, r_bg};
            4'd3: return {5'd0, r_x1, 5'd0, r_x0};
            4'd4: return {6'd0, r_y1, 6'd0, r_y0};
            4'd5: return {16'd0, fc};
            default: return 32'd0;
        endcase
    endfunction

    task automatic model_reset();
        mx = 0; my = 0; drop = 0; pdat = '0;
        {r_en, r_ie, r_tp, s_en, s_tp, eof, uf} = '0;
        {r_x0, r_x1, s_x0, s_x1, r_y0, r_y1, s_y0, s_y1, r_bg, fc} = '0;
        prev_hd = 1'b0; prev_vd = 1'b1;
    endtask

    // one clock of stimulus: check comb outputs, drive pixel, push expectations, advance the model
    task automatic cycle();
        int ax, ay;
        logic act, inw, req, nf, ef, w1c;
        logic [23:0] e;
        ax = mx - HB; ay = my - VB;
        act = mx >= HB && mx < HL - HF && my >= VB && my < VL - VF;
        inw = act && ax >= int'(s_x0) && ax <= int'(s_x1) && ay >= int'(s_y0) && ay <= int'(s_y1);
        req = s_en && act && inw && !s_tp;
        nf = mx == 0 && my == 0;
        ef = mx == HL - HF - 1 && my == VL - VF - 1;
        check("pix_req", oPIX_REQ, req);
        check("new_frame", oNewFrame, nf);
        check("end_frame", oEndFrame, ef);
        check("irq", irq, r_ie & eof);
        check("hd", oHD, prev_hd);
        check("vd", oVD, prev_vd);
        if (nf) nf_cnt++;
        if (!oHD) hd_low++;
        if (oPIX_REQ) req_cnt++;
        iPIX_VALID = !(req && drop > 0);
        if (req && drop > 0) drop--;
        iPIX_DATA = pdat;
        e = (!s_en || !act) ? 24'd0 : !inw ? r_bg : s_tp ? bars[ax / ((HL - HB - HF) / 8)] :
            iPIX_VALID ? pdat : r_bg;
        if (act) pix_exp.push_back(e);
        if (Avalon_read) rd_exp.push_back(rd_model(Avalon_address));
        @(posedge clk);
        if (nf) begin
            s_en = r_en; s_tp = r_tp; s_x0 = r_x0; s_x1 = r_x1; s_y0 = r_y0; s_y1 = r_y1;
        end
        w1c = Avalon_write && Avalon_address == 4'd1;
        eof = ef | (eof & !(w1c & Avalon_writedata[0]));
        uf = (req & !iPIX_VALID) | (uf & !(w1c & Avalon_writedata[1]));
        if (ef) fc++;
        if (Avalon_write) begin
            case (Avalon_address)
                4'd0: begin r_en = Avalon_writedata[0]; r_ie = Avalon_writedata[1]; r_tp = TP & Avalon_writedata[2]; end
                4'd2: r_bg = Avalon_writedata[23:0];
                4'd3: begin r_x0 = Avalon_writedata[10:0]; r_x1 = Avalon_writedata[26:16]; end
                4'd4: begin r_y0 = Avalon_writedata[9:0]; r_y1 = Avalon_writedata[25:16]; end
                default: ;
            endcase
        end
        prev_hd = mx != 0; prev_vd = my != 0;
        mx++;
        if (mx == HL) begin mx = 0; my = (my == VL - 1) ? 0 : my + 1; end
        pdat++;
        #1;
    endtask

    task automatic wr(input logic [3:0] a, input logic [31:0] d);
        Avalon_write = 1'b1; Avalon_address = a; Avalon_writedata = d;
        cycle();
        Avalon_write = 1'b0;
    endtask

    task automatic rd(input logic [3:0] a, output logic [31:0] d);
        Avalon_read = 1'b1; Avalon_address = a;
        cycle();
        Avalon_read = 1'b0;
        d = Avalon_readdata;
    endtask

    task automatic advance_to(input int tx, input int ty);
        for (int i = 0; i < 2 * FRAME && !(mx == tx && my == ty); i++) cycle();
        if (!(mx == tx && my == ty)) begin
            failures++;
            $display("FAIL advance_timeout actual=%0d,%0d required=%0d,%0d", mx, my, tx, ty);
        end
    endtask

    task automatic do_reset();
        Avalon_reset = 1'b1; Avalon_read = 1'b0; Avalon_write = 1'b0; iPIX_VALID = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        pix_exp.delete(); rd_exp.delete();
        model_reset();
        check("rst_hd", oHD, 0);
        check("rst_vd", oVD, 1);
        check("rst_de", oDE, 0);
        check("rst_rgb", {oLCD_R, oLCD_G, oLCD_B}, 0);
        check("rst_req", oPIX_REQ, 0);
        check("rst_irq", irq, 0);
        check("rst_rdata", Avalon_readdata, 0);
        check("rst_nf_held", oNewFrame, 0);
        Avalon_reset = 1'b0;
        #1;
        check("nf_after_reset", oNewFrame, 1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] d, v1;
        int d0, n0, h0, b0, r0;
        do_reset();
        // free-running timing over two frames with EN=0
        cycle();
        d0 = de_cnt; n0 = nf_cnt; h0 = hd_low;
        repeat (2 * FRAME) cycle();
        check("de_per_2frames", de_cnt - d0, 2 * 16 * 5);
        check("nf_per_2frames", nf_cnt - n0, 2);
        check("hd_low_per_2frames", hd_low - h0, 2 * VL);
        // full window, streaming
        wr(3, 32'h000F_0000);
        wr(4, 32'h0004_0000);
        wr(2, 32'h0012_3456);
        wr(0, 32'h1);
        rd(3, d); check("winx_readback", d, 32'h000F_0000);
        rd(0, d); check("ctrl_readback", d, 32'h1);
        advance_to(0, 0);
        repeat (FRAME) cycle();
        rd(1, d); check("status_no_uf", d, 32'h1);
        // underflow: three dropped requests
        advance_to(0, 0);
        wr(1, 32'h3);
        drop = 3;
        b0 = bg_seen;
        advance_to(0, VB + 1);
        check("bg_pixels", bg_seen - b0, 3);
        rd(1, d); check("status_uf", d, 32'h2);
        wr(1, 32'h2);
        rd(1, d); check("status_cleared", d, 32'h0);
        // window change mid-frame takes effect next frame
        wr(3, 32'h0005_0002);
        rd(3, d); check("winx_new_readback", d, 32'h0005_0002);
        advance_to(HB, VB + 3);
        check("win_old_req", oPIX_REQ, 1);
        advance_to(0, 0);
        advance_to(HB, VB + 3);
        check("win_new_x0_req", oPIX_REQ, 0);
        advance_to(HB + 2, VB + 3);
        check("win_new_x2_req", oPIX_REQ, 1);
        // empty window x0>x1
        wr(3, 32'h0001_0005);
        advance_to(0, 0);
        cycle();
        r0 = req_cnt;
        repeat (FRAME) cycle();
        check("empty_win_reqs", req_cnt - r0, 0);
        // irq and set-wins-over-clear
        wr(3, 32'h000F_0000);
        wr(0, 32'h3);
        wr(1, 32'h1);
        check("irq_cleared", irq, 0);
        advance_to(HL - HF - 1, VL - VF - 1);
        check("ef_pulse", oEndFrame, 1);
        check("irq_before_ef", irq, 0);
        wr(1, 32'h1);
        check("irq_after_ef", irq, 1);
        rd(1, d); check("eof_survives_w1c", d, 32'h1);
        rd(5, v1);
        repeat (FRAME) cycle();
        rd(5, d); check("frame_cnt_step", d - v1, 1);
        // test pattern
        wr(0, 32'h5);
`ifdef MTL_TEST_PATTERN_EN
        advance_to(0, 0);
        advance_to(HB + 1, VB);
        check("tpat_req", oPIX_REQ, 0);
        cycle();
        check("tpat_white", {oLCD_R, oLCD_G, oLCD_B}, 32'hFFFFFF);
        cycle();
        check("tpat_yellow", {oLCD_R, oLCD_G, oLCD_B}, 32'hFFFF00);
`else
        rd(0, d); check("tpat_reads_0", d, 32'h1);
`endif
        // mid-frame reset
        advance_to(5, 4);
        do_reset();
        rd(3, d); check("winx_after_reset", d, 32'h0);
        repeat (3) cycle();
        check("pix_queue_drained", pix_exp.size(), 0);
        check("rd_queue_drained", rd_exp.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
